// File: rtl/ahb3_master_bridge.sv
// Core-side command bridge: buffers valid/ready commands in a small FIFO and issues
// single, non-pipelined AHB3-Lite transfers, returning one response per command.
module ahb3_master_bridge #(
   parameter int         FIFO_AW   = 2,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        hclk,
   input  logic        hrst,
   // Both channels use plain valid/ready: a beat transfers on a rising edge where
   // valid && ready; the sender holds valid and its payload stable until then.
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [2:0]  cmd_size,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        hsel,
   output logic [31:0] haddr,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [3:0]  hprot,
   output logic [1:0]  htrans,
   output logic        hmastlock,
   output logic [31:0] hwdata,
   output logic        hready,
   input  logic [31:0] hrdata,
   input  logic        hreadyout,
   input  logic        hresp,
   output logic [1:0]  dbg_state
);

   localparam int         DEPTH        = 1 << FIFO_AW;
   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t state;

   logic [31:0]      addr_mem  [DEPTH];
   logic [31:0]      wdata_mem [DEPTH];
   logic [2:0]       size_mem  [DEPTH];
   logic             write_mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;

   logic        empty;
   logic        full;
   logic        push;
   logic        slot_free;
   logic [31:0] head_addr;
   logic [31:0] head_wdata;
   logic [2:0]  head_size;
   logic        head_write;
   logic        head_illegal;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

   assign cmd_ready = hrst && !full;
   assign push      = cmd_valid && cmd_ready;
   assign slot_free = !rsp_valid || rsp_ready;

   assign head_addr  = addr_mem[rd_ptr[FIFO_AW-1:0]];
   assign head_wdata = wdata_mem[rd_ptr[FIFO_AW-1:0]];
   assign head_size  = size_mem[rd_ptr[FIFO_AW-1:0]];
   assign head_write = write_mem[rd_ptr[FIFO_AW-1:0]];

   assign head_illegal = (head_size > 3'd2) ||
                         ((head_size == 3'd1) && head_addr[0]) ||
                         ((head_size == 3'd2) && (head_addr[1:0] != 2'b00));

   assign hready    = hreadyout;
   assign hburst    = 3'b000;
   assign hprot     = HPROT_VAL;
   assign hmastlock = 1'b0;
   assign dbg_state = state;

   always_ff @(posedge hclk) begin
      if (push) begin
         addr_mem[wr_ptr[FIFO_AW-1:0]]  <= cmd_addr;
         wdata_mem[wr_ptr[FIFO_AW-1:0]] <= cmd_wdata;
         size_mem[wr_ptr[FIFO_AW-1:0]]  <= cmd_size;
         write_mem[wr_ptr[FIFO_AW-1:0]] <= cmd_write;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hrst) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         hsel      <= 1'b0;
         htrans    <= TRANS_IDLE;
         haddr     <= '0;
         hwrite    <= 1'b0;
         hsize     <= '0;
         hwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (!empty && slot_free) begin
                  if (head_illegal) begin
                     // Rejected locally: answer with an error and never touch the bus.
                     rd_ptr    <= rd_ptr + 1'b1;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state  <= ST_ADDR;
                     hsel   <= 1'b1;
                     htrans <= TRANS_NONSEQ;
                     haddr  <= head_addr;
                     hwrite <= head_write;
                     hsize  <= head_size;
                  end
               end
            end
            ST_ADDR: begin
               if (hreadyout) begin
                  state  <= ST_DATA;
                  hsel   <= 1'b0;
                  htrans <= TRANS_IDLE;
                  hwdata <= head_write ? head_wdata : 32'h0;
               end
            end
            ST_DATA: begin
               if (hreadyout) begin
                  state     <= ST_IDLE;
                  rd_ptr    <= rd_ptr + 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= hresp;
                  rsp_rdata <= (!hwrite && !hresp) ? hrdata : 32'h0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb3_master_bridge.sv
// Directed bench for ahb3_master_bridge: the bench plays the AHB slave by hand and
// scores every response against an expected queue.
module tb_ahb3_master_bridge;

   logic        hclk;
   logic        hrst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic        hready;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;
   logic [1:0]  dbg_state;

   logic        rdata_mode;
   logic [31:0] rdata_fix;
   logic        watch_hsel;
   logic        hsel_seen;

   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_exp    = 0;
   int          n_rsp    = 0;
   int          n_snap;

   // In address mode the slave returns a tag derived from the latched address.
   assign hrdata = rdata_mode ? {16'hC0DE, haddr[15:0]} : rdata_fix;

   ahb3_master_bridge #(.FIFO_AW(2), .HPROT_VAL(4'b0011)) dut (
      .hclk(hclk), .hrst(hrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
      .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
      .hready(hready), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
      .dbg_state(dbg_state)
   );

   // Clock and watchdog
   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_rsp(input logic err, input logic [31:0] data);
      exp_q.push_back({err, data});
      n_exp++;
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz);
      logic done;
      done      = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_size  = sz;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         done = cmd_ready;
         @(negedge hclk);
      end
      cmd_valid = 1'b0;
      check("push_accept", 64'(done), 64'(1'b1));
   endtask

   // Response scoreboard, sampled mid-low-phase
   always @(negedge hclk) begin
      logic [32:0] e;
      #2;
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp", 64'({rsp_err, rsp_rdata}), 64'(e));
         end
      end
   end

   always @(negedge hclk) begin
      #3;
      if (watch_hsel && hsel) hsel_seen = 1'b1;
   end

   initial begin
      hrst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_size = '0; rsp_ready = 1'b1; hreadyout = 1'b1; hresp = 1'b0;
      rdata_mode = 1'b0; rdata_fix = '0; watch_hsel = 1'b0; hsel_seen = 1'b0;

      // Reset values
      repeat (3) @(negedge hclk);
      check("rst_hsel", 64'(hsel), 64'(1'b0));
      check("rst_htrans", 64'(htrans), 64'(2'b00));
      check("rst_haddr", 64'(haddr), 64'(32'h0));
      check("rst_hwdata", 64'(hwdata), 64'(32'h0));
      check("rst_hwrite", 64'(hwrite), 64'(1'b0));
      check("rst_hsize", 64'(hsize), 64'(3'd0));
      check("rst_hburst", 64'(hburst), 64'(3'd0));
      check("rst_hmastlock", 64'(hmastlock), 64'(1'b0));
      check("rst_hprot", 64'(hprot), 64'(4'b0011));
      check("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
      check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(34'h0));
      hrst = 1'b1;
      @(negedge hclk);
      check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));

      // Write then read
      expect_rsp(1'b0, 32'h0);
      push_cmd(1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
      check("wr_idle_rsp", 64'(rsp_valid), 64'(1'b0));
      @(negedge hclk);
      check("wr_addr_hsel", 64'(hsel), 64'(1'b1));
      check("wr_addr_htrans", 64'(htrans), 64'(2'b10));
      check("wr_addr_haddr", 64'(haddr), 64'(32'h10));
      check("wr_addr_hwrite", 64'(hwrite), 64'(1'b1));
      check("wr_addr_hsize", 64'(hsize), 64'(3'd2));
      @(negedge hclk);
      check("wr_data_hsel", 64'(hsel), 64'(1'b0));
      check("wr_data_htrans", 64'(htrans), 64'(2'b00));
      check("wr_data_hwdata", 64'(hwdata), 64'(32'hDEADBEEF));
      check("wr_data_rsp", 64'(rsp_valid), 64'(1'b0));
      @(negedge hclk);
      check("wr_latency", 64'(rsp_valid), 64'(1'b1));

      rdata_fix = 32'hDEADBEEF;
      expect_rsp(1'b0, 32'hDEADBEEF);
      push_cmd(1'b0, 32'h10, 32'h0, 3'd2);
      @(negedge hclk);
      check("rd_addr_haddr", 64'(haddr), 64'(32'h10));
      check("rd_addr_hwrite", 64'(hwrite), 64'(1'b0));
      @(negedge hclk);
      check("rd_data_hwdata", 64'(hwdata), 64'(32'h0));
      @(negedge hclk);
      check("rd_latency", 64'(rsp_valid), 64'(1'b1));

      // Read with three data-phase wait states
      expect_rsp(1'b0, 32'h12345678);
      push_cmd(1'b0, 32'h20, 32'hFFFFFFFF, 3'd2);
      @(negedge hclk);
      check("ws_addr_haddr", 64'(haddr), 64'(32'h20));
      @(negedge hclk);
      hreadyout = 1'b0;
      rdata_fix = 32'h0;
      for (int k = 0; k < 3; k++) begin
         check("ws_haddr", 64'(haddr), 64'(32'h20));
         check("ws_hwdata", 64'(hwdata), 64'(32'h0));
         check("ws_htrans", 64'(htrans), 64'(2'b00));
         check("ws_rsp", 64'(rsp_valid), 64'(1'b0));
         if (k > 0) check("ws_hready", 64'(hready), 64'(1'b0));
         @(negedge hclk);
      end
      hreadyout = 1'b1;
      rdata_fix = 32'h12345678;
      check("ws_rsp_late", 64'(rsp_valid), 64'(1'b0));
      @(negedge hclk);
      check("ws_latency", 64'(rsp_valid), 64'(1'b1));

      // Two-cycle error response, then a queued write proceeds
      expect_rsp(1'b1, 32'h0);
      push_cmd(1'b0, 32'h30, 32'h0, 3'd2);
      expect_rsp(1'b0, 32'h0);
      push_cmd(1'b1, 32'h34, 32'hA5A55A5A, 3'd2);
      check("err_addr_haddr", 64'(haddr), 64'(32'h30));
      check("err_addr_hsel", 64'(hsel), 64'(1'b1));
      @(negedge hclk);
      hresp = 1'b1; hreadyout = 1'b0; rdata_fix = 32'hBAD0BAD0;
      check("err_htrans1", 64'(htrans), 64'(2'b00));
      check("err_hsel1", 64'(hsel), 64'(1'b0));
      @(negedge hclk);
      check("err_htrans2", 64'(htrans), 64'(2'b00));
      check("err_rsp_early", 64'(rsp_valid), 64'(1'b0));
      hreadyout = 1'b1;
      @(negedge hclk);
      hresp = 1'b0;
      check("err_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b11, 32'h0}));
      @(negedge hclk);
      check("err_next_haddr", 64'(haddr), 64'(32'h34));
      check("err_next_hsel", 64'(hsel), 64'(1'b1));
      check("err_next_hwrite", 64'(hwrite), 64'(1'b1));
      @(negedge hclk);
      check("err_next_hwdata", 64'(hwdata), 64'(32'hA5A55A5A));
      @(negedge hclk);
      check("err_next_rsp", 64'(rsp_valid), 64'(1'b1));

      // Illegal commands never reach the bus
      hsel_seen = 1'b0; watch_hsel = 1'b1;
      expect_rsp(1'b1, 32'h0);
      push_cmd(1'b0, 32'h0, 32'h0, 3'd3);
      expect_rsp(1'b1, 32'h0);
      push_cmd(1'b0, 32'h2, 32'h0, 3'd2);
      expect_rsp(1'b1, 32'h0);
      push_cmd(1'b1, 32'h1, 32'h0, 3'd1);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge hclk);
      @(negedge hclk);
      watch_hsel = 1'b0;
      check("ill_no_hsel", 64'(hsel_seen), 64'(1'b0));
      check("ill_drained", 64'(exp_q.size()), 64'(0));

      // Backpressure: response held, FIFO fills
      rsp_ready = 1'b0;
      rdata_mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [31:0] a;
         a = 32'h100 + 32'(4 * i);
         expect_rsp(1'b0, {16'hC0DE, a[15:0]});
         push_cmd(1'b0, a, 32'h0, 3'd2);
      end
      check("full_cmd_ready", 64'(cmd_ready), 64'(1'b0));
      hsel_seen = 1'b0; watch_hsel = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_size = 3'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge hclk);
         check("full_hold_ready", 64'(cmd_ready), 64'(1'b0));
         check("full_hold_rsp", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, 32'hC0DE0100}));
      end
      cmd_valid = 1'b0;
      watch_hsel = 1'b0;
      check("full_one_xfer", 64'(hsel_seen), 64'(1'b0));
      rsp_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge hclk);
      @(negedge hclk);
      check("full_drained", 64'(exp_q.size()), 64'(0));
      rdata_mode = 1'b0;

      // Reset during a write data phase
      n_snap = n_rsp;
      push_cmd(1'b1, 32'h60, 32'h11223344, 3'd2);
      @(negedge hclk);
      @(negedge hclk);
      check("rst_mid_hwdata", 64'(hwdata), 64'(32'h11223344));
      hrst = 1'b0;
      @(negedge hclk);
      check("rst_mid_bus", 64'({hsel, htrans, hwrite, hsize}), 64'(7'h0));
      check("rst_mid_haddr", 64'(haddr), 64'(32'h0));
      check("rst_mid_hwdata0", 64'(hwdata), 64'(32'h0));
      check("rst_mid_rsp", 64'(rsp_valid), 64'(1'b0));
      check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1'b0));
      check("rst_mid_state", 64'(dbg_state), 64'(2'd0));
      hrst = 1'b1;
      hsel_seen = 1'b0; watch_hsel = 1'b1;
      repeat (8) @(negedge hclk);
      watch_hsel = 1'b0;
      check("rst_mid_no_xfer", 64'(hsel_seen), 64'(1'b0));
      check("rst_mid_no_rsp", 64'(n_rsp), 64'(n_snap));

      check("rsp_count", 64'(n_rsp), 64'(n_exp));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
